// File: rtl/rgb444_to_gray_if.sv
// ============================================================================
//  Module      : rgb444_to_gray_if
//  Description : Pixel stream bundle into and out of the RGB444-to-luma stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb444_to_gray_if;
  logic        smooth_en;
  logic        pix_valid;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [11:0] rgb_in;
  logic [7:0]  gray;
  logic [9:0]  gray_x;
  logic [9:0]  gray_y;
  logic        gray_valid;

  modport master (
    output smooth_en, pix_valid, pos_x, pos_y, rgb_in,
    input  gray, gray_x, gray_y, gray_valid
  );

  modport slave (
    input  smooth_en, pix_valid, pos_x, pos_y, rgb_in,
    output gray, gray_x, gray_y, gray_valid
  );
endinterface

`default_nettype wire

// File: rtl/rgb444_to_gray.sv
// ============================================================================
//  Module      : rgb444_to_gray
//  Description : RGB444 -> 8-bit luma, 4-cycle pipeline with optional
//                [1 2 1]/4 horizontal smoothing; position/valid kept aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb444_to_gray #(
  parameter int LATENCY = 4,
  parameter int COL_NUM = 640
) (
  input  wire logic           vga_clk,
  input  wire logic           rst_n,
  rgb444_to_gray_if.slave     bus
);

  localparam logic [15:0] C_KR     = 16'd77;
  localparam logic [15:0] C_KG     = 16'd150;
  localparam logic [15:0] C_KB     = 16'd29;
  localparam logic [9:0]  C_X_LAST = 10'(COL_NUM - 1);

  if (LATENCY != 4) begin : g_latency_guard
    $error("rgb444_to_gray: LATENCY is fixed at 4");
  end

  // Stage 1: weighted channels
  logic [15:0] p_r_q, p_g_q, p_b_q;
  logic [9:0]  s1_x_q, s1_y_q;
  logic        s1_v_q, s1_m_q;
  // Stage 2: luma
  logic [7:0]  y2_q;
  logic [9:0]  s2_x_q, s2_y_q;
  logic        s2_v_q, s2_m_q;
  // Stage 3: centre and its left neighbour
  logic [7:0]  c_q, l_q;
  logic [9:0]  c_x_q, c_y_q, l_y_q;
  logic        c_v_q, c_m_q, l_v_q;
  // Stage 4: outputs
  logic [7:0]  gray_q;
  logic [9:0]  gray_x_q, gray_y_q;
  logic        gray_valid_q;
  logic        mode_q;

  logic [7:0]  r8_d, g8_d, b8_d;
  logic        frame_start_d, mode_d;
  logic [15:0] sum_d;
  logic [7:0]  luma_d, left_d, right_d, gray_d;
  logic [9:0]  ssum_d;

  assign r8_d = {bus.rgb_in[11:8], bus.rgb_in[11:8]};
  assign g8_d = {bus.rgb_in[7:4],  bus.rgb_in[7:4]};
  assign b8_d = {bus.rgb_in[3:0],  bus.rgb_in[3:0]};

  // The mode travels with each pixel, so a frame-start change never splits a frame.
  assign frame_start_d = bus.pix_valid && (bus.pos_x == 10'd0) && (bus.pos_y == 10'd0);
  assign mode_d        = frame_start_d ? bus.smooth_en : mode_q;

  assign sum_d  = p_r_q + p_g_q + p_b_q;
  assign luma_d = 8'(sum_d >> 8);

  assign left_d  = (!l_v_q || (l_y_q != c_y_q) || (c_x_q == 10'd0)) ? c_q : l_q;
  assign right_d = (!s2_v_q || (s2_y_q != c_y_q) || (s2_x_q != c_x_q + 10'd1) ||
                    (c_x_q == C_X_LAST)) ? c_q : y2_q;
  assign ssum_d  = {2'b00, left_d} + {1'b0, c_q, 1'b0} + {2'b00, right_d};

  always_comb begin
    gray_d = 8'd0;
    if (c_v_q) begin
      gray_d = c_m_q ? 8'(ssum_d >> 2) : c_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      mode_q       <= 1'b0;
      p_r_q        <= 16'd0;
      p_g_q        <= 16'd0;
      p_b_q        <= 16'd0;
      s1_x_q       <= 10'd0;
      s1_y_q       <= 10'd0;
      s1_v_q       <= 1'b0;
      s1_m_q       <= 1'b0;
      y2_q         <= 8'd0;
      s2_x_q       <= 10'd0;
      s2_y_q       <= 10'd0;
      s2_v_q       <= 1'b0;
      s2_m_q       <= 1'b0;
      c_q          <= 8'd0;
      c_x_q        <= 10'd0;
      c_y_q        <= 10'd0;
      c_v_q        <= 1'b0;
      c_m_q        <= 1'b0;
      l_q          <= 8'd0;
      l_y_q        <= 10'd0;
      l_v_q        <= 1'b0;
      gray_q       <= 8'd0;
      gray_x_q     <= 10'd0;
      gray_y_q     <= 10'd0;
      gray_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      p_r_q        <= C_KR * {8'd0, r8_d};
      p_g_q        <= C_KG * {8'd0, g8_d};
      p_b_q        <= C_KB * {8'd0, b8_d};
      s1_x_q       <= bus.pos_x;
      s1_y_q       <= bus.pos_y;
      s1_v_q       <= bus.pix_valid;
      s1_m_q       <= mode_d;
      y2_q         <= luma_d;
      s2_x_q       <= s1_x_q;
      s2_y_q       <= s1_y_q;
      s2_v_q       <= s1_v_q;
      s2_m_q       <= s1_m_q;
      c_q          <= y2_q;
      c_x_q        <= s2_x_q;
      c_y_q        <= s2_y_q;
      c_v_q        <= s2_v_q;
      c_m_q        <= s2_m_q;
      l_q          <= c_q;
      l_y_q        <= c_y_q;
      l_v_q        <= c_v_q;
      gray_q       <= gray_d;
      gray_x_q     <= c_x_q;
      gray_y_q     <= c_y_q;
      gray_valid_q <= c_v_q;
    end
  end

  assign bus.gray       = gray_q;
  assign bus.gray_x     = gray_x_q;
  assign bus.gray_y     = gray_y_q;
  assign bus.gray_valid = gray_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb444_to_gray.sv
// ============================================================================
//  Module      : tb_rgb444_to_gray
//  Description : Directed self-checking bench for rgb444_to_gray.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb444_to_gray;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_run   = 0;
  int   n_fail  = 0;

  always #5 vga_clk = ~vga_clk;

  rgb444_to_gray_if u_if ();

  rgb444_to_gray u_dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (u_if.slave)
  );

  // Stimulus vectors and captured outputs, index-aligned (capture k = output of vector k)
  logic        v_v  [16];
  logic        v_sm [16];
  logic [9:0]  v_x  [16];
  logic [9:0]  v_y  [16];
  logic [11:0] v_rgb[16];
  logic [7:0]  e_gray[16];
  logic [7:0]  o_gray[16];
  logic [9:0]  o_x  [16];
  logic [9:0]  o_y  [16];
  logic        o_v  [16];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] rgb, input logic sm);
    u_if.pix_valid = v;
    u_if.pos_x     = x;
    u_if.pos_y     = y;
    u_if.rgb_in    = rgb;
    u_if.smooth_en = sm;
  endtask

  task automatic vec(input int i, input logic v, input logic [9:0] x, input logic [9:0] y,
                     input logic [11:0] rgb, input logic sm, input logic [7:0] eg);
    v_v[i] = v; v_x[i] = x; v_y[i] = y; v_rgb[i] = rgb; v_sm[i] = sm; e_gray[i] = eg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) drive(v_v[i], v_x[i], v_y[i], v_rgb[i], v_sm[i]);
      else       drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
      step();
      if (i >= 3) begin
        o_gray[i-3] = u_if.gray;
        o_x[i-3]    = u_if.gray_x;
        o_y[i-3]    = u_if.gray_y;
        o_v[i-3]    = u_if.gray_valid;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 10'd3, 10'd4, 12'hFFF, 1'b1);
    step();
    step();
    n_run += 4;
    if (u_if.gray !== 8'd0)        begin n_fail++; $display("FAIL reset_gray: got %0d expected 0", u_if.gray); end
    if (u_if.gray_x !== 10'd0)     begin n_fail++; $display("FAIL reset_gray_x: got %0d expected 0", u_if.gray_x); end
    if (u_if.gray_y !== 10'd0)     begin n_fail++; $display("FAIL reset_gray_y: got %0d expected 0", u_if.gray_y); end
    if (u_if.gray_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", u_if.gray_valid); end
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    drive(1'b1, 10'd5, 10'd7, 12'hFFF, 1'b0);
    step();
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step();
      if (c < 4) begin
        n_run++;
        if (u_if.gray_valid !== 1'b0) begin
          n_fail++; $display("FAIL latency_early_valid@%0d: got %0b expected 0", c, u_if.gray_valid);
        end
      end
    end
    n_run += 4;
    if (u_if.gray !== 8'd255)     begin n_fail++; $display("FAIL latency_gray: got %0d expected 255", u_if.gray); end
    if (u_if.gray_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %0b expected 1", u_if.gray_valid); end
    if (u_if.gray_x !== 10'd5)    begin n_fail++; $display("FAIL latency_x: got %0d expected 5", u_if.gray_x); end
    if (u_if.gray_y !== 10'd7)    begin n_fail++; $display("FAIL latency_y: got %0d expected 7", u_if.gray_y); end
  endtask

  task automatic test_bypass();
    vec(0, 1'b1, 10'd0,  10'd0, 12'hFFF, 1'b0, 8'd255);
    vec(1, 1'b1, 10'd10, 10'd2, 12'hF00, 1'b0, 8'd76);
    vec(2, 1'b1, 10'd11, 10'd2, 12'h0F0, 1'b0, 8'd149);
    vec(3, 1'b1, 10'd12, 10'd2, 12'h00F, 1'b0, 8'd28);
    vec(4, 1'b1, 10'd13, 10'd2, 12'h000, 1'b0, 8'd0);
    run(5);
    for (int k = 0; k < 5; k++) begin
      n_run += 2;
      if (o_gray[k] !== e_gray[k]) begin n_fail++; $display("FAIL bypass_gray[%0d]: got %0d expected %0d", k, o_gray[k], e_gray[k]); end
      if (o_x[k] !== v_x[k] || o_y[k] !== v_y[k] || o_v[k] !== 1'b1) begin
        n_fail++; $display("FAIL bypass_pos[%0d]: got x=%0d y=%0d v=%0b expected x=%0d y=%0d v=1", k, o_x[k], o_y[k], o_v[k], v_x[k], v_y[k]);
      end
    end
  endtask

  task automatic test_smooth();
    vec(0, 1'b1, 10'd0, 10'd0, 12'h000, 1'b1, 8'd63);
    vec(1, 1'b1, 10'd1, 10'd0, 12'hFFF, 1'b1, 8'd127);
    vec(2, 1'b1, 10'd2, 10'd0, 12'h000, 1'b1, 8'd63);
    vec(3, 1'b1, 10'd3, 10'd0, 12'h000, 1'b1, 8'd0);
    run(4);
    for (int k = 0; k < 4; k++) begin
      n_run += 2;
      if (o_gray[k] !== e_gray[k]) begin n_fail++; $display("FAIL smooth_gray[%0d]: got %0d expected %0d", k, o_gray[k], e_gray[k]); end
      if (o_x[k] !== v_x[k] || o_v[k] !== 1'b1) begin
        n_fail++; $display("FAIL smooth_pos[%0d]: got x=%0d v=%0b expected x=%0d v=1", k, o_x[k], o_v[k], v_x[k]);
      end
    end
  endtask

  task automatic test_row_edge();
    vec(0, 1'b1, 10'd0,   10'd0, 12'h000, 1'b1, 8'd0);
    vec(1, 1'b1, 10'd638, 10'd5, 12'hFFF, 1'b1, 8'd255);
    vec(2, 1'b1, 10'd639, 10'd5, 12'hFFF, 1'b1, 8'd255);
    vec(3, 1'b0, 10'd0,   10'd0, 12'h000, 1'b0, 8'd0);
    vec(4, 1'b1, 10'd639, 10'd8, 12'hFFF, 1'b1, 8'd255);
    vec(5, 1'b1, 10'd0,   10'd9, 12'h000, 1'b1, 8'd0);
    vec(6, 1'b1, 10'd1,   10'd9, 12'h000, 1'b1, 8'd0);
    run(7);
    for (int k = 0; k < 7; k++) begin
      n_run += 2;
      if (o_gray[k] !== e_gray[k]) begin n_fail++; $display("FAIL edge_gray[%0d]: got %0d expected %0d", k, o_gray[k], e_gray[k]); end
      if (o_v[k] !== v_v[k] || o_x[k] !== v_x[k]) begin
        n_fail++; $display("FAIL edge_pos[%0d]: got x=%0d v=%0b expected x=%0d v=%0b", k, o_x[k], o_v[k], v_x[k], v_v[k]);
      end
    end
  endtask

  task automatic test_mode_switch();
    vec(0, 1'b1, 10'd0,   10'd0, 12'h000, 1'b1, 8'd0);
    vec(1, 1'b1, 10'd99,  10'd3, 12'h000, 1'b1, 8'd63);
    vec(2, 1'b1, 10'd100, 10'd3, 12'hFFF, 1'b0, 8'd127);
    vec(3, 1'b1, 10'd101, 10'd3, 12'h000, 1'b0, 8'd63);
    vec(4, 1'b1, 10'd0,   10'd0, 12'h000, 1'b0, 8'd0);
    vec(5, 1'b1, 10'd1,   10'd0, 12'hFFF, 1'b0, 8'd255);
    vec(6, 1'b1, 10'd2,   10'd0, 12'h000, 1'b1, 8'd0);
    vec(7, 1'b1, 10'd3,   10'd0, 12'hFFF, 1'b1, 8'd255);
    run(8);
    for (int k = 0; k < 8; k++) begin
      n_run += 2;
      if (o_gray[k] !== e_gray[k]) begin n_fail++; $display("FAIL mode_gray[%0d]: got %0d expected %0d", k, o_gray[k], e_gray[k]); end
      if (o_x[k] !== v_x[k] || o_v[k] !== 1'b1) begin
        n_fail++; $display("FAIL mode_pos[%0d]: got x=%0d v=%0b expected x=%0d v=1", k, o_x[k], o_v[k], v_x[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'(i), 10'd0, 12'hFFF, 1'b1);
      step();
    end
    n_run++;
    if (u_if.gray_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %0b expected 1", u_if.gray_valid); end
    rst_n = 1'b0;
    drive(1'b1, 10'd5, 10'd0, 12'hFFF, 1'b1);
    step();
    n_run += 4;
    if (u_if.gray !== 8'd0)       begin n_fail++; $display("FAIL midrst_gray: got %0d expected 0", u_if.gray); end
    if (u_if.gray_x !== 10'd0)    begin n_fail++; $display("FAIL midrst_x: got %0d expected 0", u_if.gray_x); end
    if (u_if.gray_y !== 10'd0)    begin n_fail++; $display("FAIL midrst_y: got %0d expected 0", u_if.gray_y); end
    if (u_if.gray_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", u_if.gray_valid); end
    rst_n = 1'b1;
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_run++;
      if (u_if.gray_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush[%0d]: got %0b expected 0", i, u_if.gray_valid); end
    end
    // Not a frame start, so the post-reset mode must stay bypass despite smooth_en=1
    drive(1'b1, 10'd5, 10'd1, 12'hFFF, 1'b1);
    step();
    drive(1'b1, 10'd6, 10'd1, 12'h000, 1'b1);
    step();
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    step();
    n_run++;
    if (u_if.gray_valid !== 1'b0) begin n_fail++; $display("FAIL recover_early_valid: got %0b expected 0", u_if.gray_valid); end
    step();
    n_run += 3;
    if (u_if.gray_valid !== 1'b1) begin n_fail++; $display("FAIL recover_valid: got %0b expected 1", u_if.gray_valid); end
    if (u_if.gray !== 8'd255)     begin n_fail++; $display("FAIL recover_gray0: got %0d expected 255", u_if.gray); end
    if (u_if.gray_x !== 10'd5)    begin n_fail++; $display("FAIL recover_x0: got %0d expected 5", u_if.gray_x); end
    step();
    n_run += 2;
    if (u_if.gray !== 8'd0)       begin n_fail++; $display("FAIL recover_gray1: got %0d expected 0", u_if.gray); end
    if (u_if.gray_x !== 10'd6)    begin n_fail++; $display("FAIL recover_x1: got %0d expected 6", u_if.gray_x); end
  endtask

  initial begin
    drive(1'b0, 10'd0, 10'd0, 12'h000, 1'b0);
    test_reset();
    test_latency();
    test_bypass();
    test_smooth();
    test_row_edge();
    test_mode_switch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
